// File: rtl/key_event_queue.sv
// Keypad event front end: debounces the synchronized key code, emits one event per
// accepted press plus optional hold-to-repeat events, and queues them for SPI polling.
module key_event_queue #(
  parameter int unsigned DEBOUNCE_CYCLES = 800000,
  parameter int unsigned REPEAT_DELAY    = 8000000,
  parameter int unsigned REPEAT_PERIOD   = 4000000,
  parameter int unsigned DEPTH           = 4,
  parameter logic [3:0]  IDLE_CODE       = 4'hD
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [3:0]               key_in,
  input  logic                     pop,
  output logic [7:0]               key_byte,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNW  = AW + 1;
  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 2);
  localparam logic [7:0] EMPTY_BYTE = 8'h0D;

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_e;

  state_e                    state_q, state_d;
  logic [3:0]                cand_q, cand_d, held_q, held_d;
  logic [DW-1:0]             cnt_q, cnt_d;
  logic [RW-1:0]             rpt_q, rpt_d, rpt_inc, rpt_lim;
  logic                      first_q, first_d;
  logic                      stable, push;
  logic [DEPTH-1:0][3:0]     mem_q;
  logic [AW-1:0]             wr_q, wr_d, rd_q, rd_d;
  logic [CNW-1:0]            count_q, count_d;
  logic [7:0]                key_byte_q, key_byte_d;
  logic                      empty_q, ovf_q, ovf_d;
  logic                      do_push, do_pop;
  logic [3:0]                head_code;

  // Debounce tracker and event FSM. cand follows every sample; held remembers the
  // accepted key so a bounce during release can be recognised.
  always_comb begin
    state_d = state_q;
    held_d  = held_q;
    rpt_d   = rpt_q;
    first_d = first_q;
    push    = 1'b0;
    cand_d  = key_in;
    if (key_in == cand_q)
      cnt_d = (cnt_q == DW'(DEBOUNCE_CYCLES)) ? cnt_q : cnt_q + DW'(1);
    else
      cnt_d = DW'(1);
    stable  = (cnt_d == DW'(DEBOUNCE_CYCLES));
    rpt_inc = rpt_q + RW'(1);
    rpt_lim = first_q ? RW'(REPEAT_DELAY) : RW'(REPEAT_PERIOD);

    case (state_q)
      IDLE: begin
        if (key_in != IDLE_CODE) state_d = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (key_in == IDLE_CODE) state_d = IDLE;
      end
      HELD: begin
        if (key_in == held_q) begin
          rpt_d = rpt_inc;
          if (REPEAT_DELAY != 0 && rpt_inc == rpt_lim) begin
            push    = 1'b1;
            rpt_d   = '0;
            first_d = 1'b0;
          end
        end else begin
          state_d = RELEASE_WAIT;
        end
      end
      RELEASE_WAIT: begin
        if (key_in == held_q) state_d = HELD;
      end
      default: state_d = IDLE;
    endcase

    // Debounced acceptance: new press from PRESS_WAIT/IDLE, or a new key during release.
    if (stable && key_in != IDLE_CODE && state_q != HELD && !(state_q == RELEASE_WAIT && key_in == held_q)) begin
      push    = 1'b1;
      held_d  = key_in;
      rpt_d   = '0;
      first_d = 1'b1;
      state_d = HELD;
    end else if (stable && key_in == IDLE_CODE && state_q == RELEASE_WAIT) begin
      state_d = IDLE;
    end
  end

  // FIFO: a full FIFO still accepts a push when the same edge pops.
  always_comb begin
    do_pop  = pop && (count_q != '0);
    do_push = push && ((count_q != CNW'(DEPTH)) || do_pop);
    ovf_d   = ovf_q | (push && !do_push);
    wr_d    = wr_q + AW'(do_push);
    rd_d    = rd_q + AW'(do_pop);
    count_d = count_q + CNW'(do_push) - CNW'(do_pop);
    head_code  = (do_push && wr_q == rd_d) ? key_in : mem_q[rd_d];
    key_byte_d = (count_d == '0) ? EMPTY_BYTE : {4'b1000, head_code};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cand_q     <= '0;
      cnt_q      <= '0;
      held_q     <= '0;
      rpt_q      <= '0;
      first_q    <= 1'b0;
      mem_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
      key_byte_q <= EMPTY_BYTE;
      empty_q    <= 1'b1;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      held_q     <= held_d;
      rpt_q      <= rpt_d;
      first_q    <= first_d;
      if (do_push) mem_q[wr_q] <= key_in;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      count_q    <= count_d;
      key_byte_q <= key_byte_d;
      empty_q    <= (count_d == '0);
      ovf_q      <= ovf_d;
    end
  end

  assign key_byte = key_byte_q;
  assign empty    = empty_q;
  assign count    = count_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_key_event_queue.sv
// Directed bench for key_event_queue with short debounce/repeat parameters.
module tb_key_event_queue;
  logic       clk, reset, pop, empty, overflow;
  logic [3:0] key_in;
  logic [7:0] key_byte;
  logic [2:0] count;
  int n_tests = 0;
  int n_fail  = 0;

  key_event_queue #(
    .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3), .DEPTH(4), .IDLE_CODE(4'hD)
  ) dut (
    .clk(clk), .reset(reset), .key_in(key_in), .pop(pop),
    .key_byte(key_byte), .empty(empty), .count(count), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; the next rising edge consumes them.
  task automatic cyc(input logic [3:0] k, input logic p);
    key_in = k;
    pop    = p;
    @(negedge clk);
    pop    = 1'b0;
  endtask

  task automatic press(input logic [3:0] k);
    for (int i = 0; i < 4; i++) cyc(k, 1'b0);
    for (int i = 0; i < 4; i++) cyc(4'hD, 1'b0);
  endtask

  task automatic do_reset(input logic [3:0] k);
    reset = 1'b1;
    cyc(k, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; key_in = 4'hD; pop = 1'b0;
    @(negedge clk);
    cyc(4'hD, 1'b0);
    reset = 1'b0;
    chk("rst_byte", 32'(key_byte), 32'h0D);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_count", 32'(count), 0);
    chk("rst_ovf", 32'(overflow), 0);

    // single press
    for (int i = 0; i < 3; i++) cyc(4'h5, 1'b0);
    chk("pre_accept_count", 32'(count), 0);
    cyc(4'h5, 1'b0);
    chk("press_byte", 32'(key_byte), 32'h85);
    chk("press_count", 32'(count), 1);
    for (int i = 0; i < 5; i++) cyc(4'h5, 1'b0);
    chk("hold_byte", 32'(key_byte), 32'h85);
    chk("hold_count", 32'(count), 1);
    for (int i = 0; i < 4; i++) cyc(4'hD, 1'b0);
    cyc(4'hD, 1'b1);
    chk("pop1_byte", 32'(key_byte), 32'h0D);
    chk("pop1_empty", 32'(empty), 1);

    // bouncing key never accepted
    for (int i = 0; i < 20; i++) cyc((i % 2 == 0) ? 4'h5 : 4'hD, 1'b0);
    chk("bounce_count", 32'(count), 0);
    chk("bounce_byte", 32'(key_byte), 32'h0D);

    // hold-to-repeat: accept at sample 4, repeats at 14 and 17
    for (int i = 1; i <= 19; i++) begin
      cyc(4'h3, 1'b0);
      if (i == 13) chk("rpt_before_delay", 32'(count), 1);
      if (i == 14) chk("rpt_first", 32'(count), 2);
      if (i == 16) chk("rpt_before_period", 32'(count), 2);
      if (i == 17) chk("rpt_second", 32'(count), 3);
    end
    chk("rpt_total", 32'(count), 3);
    chk("rpt_byte", 32'(key_byte), 32'h83);
    cyc(4'hD, 1'b1);
    chk("rpt_pop1", 32'(key_byte), 32'h83);
    cyc(4'hD, 1'b1);
    chk("rpt_pop2", 32'(key_byte), 32'h83);
    cyc(4'hD, 1'b1);
    chk("rpt_pop3", 32'(key_byte), 32'h0D);
    cyc(4'hD, 1'b0);
    for (int i = 0; i < 4; i++) cyc(4'h3, 1'b0);
    chk("repress_count", 32'(count), 1);
    chk("repress_byte", 32'(key_byte), 32'h83);
    cyc(4'hD, 1'b1);
    for (int i = 0; i < 3; i++) cyc(4'hD, 1'b0);
    chk("repress_empty", 32'(empty), 1);

    // overflow
    press(4'h1); press(4'h2); press(4'h3); press(4'h4);
    chk("full_count", 32'(count), 4);
    chk("full_ovf", 32'(overflow), 0);
    press(4'h6);
    chk("ovf_count", 32'(count), 4);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_head", 32'(key_byte), 32'h81);
    cyc(4'hD, 1'b1); chk("drain1", 32'(key_byte), 32'h82);
    cyc(4'hD, 1'b1); chk("drain2", 32'(key_byte), 32'h83);
    cyc(4'hD, 1'b1); chk("drain3", 32'(key_byte), 32'h84);
    cyc(4'hD, 1'b1); chk("drain4", 32'(key_byte), 32'h0D);
    chk("drain_empty", 32'(empty), 1);

    // push and pop on the same edge, full and empty
    do_reset(4'hD);
    press(4'h1); press(4'h2); press(4'h3); press(4'h4);
    for (int i = 0; i < 3; i++) cyc(4'h7, 1'b0);
    cyc(4'h7, 1'b1);
    chk("pp_full_count", 32'(count), 4);
    chk("pp_full_ovf", 32'(overflow), 0);
    chk("pp_full_head", 32'(key_byte), 32'h82);
    cyc(4'hD, 1'b1); chk("pp_drain1", 32'(key_byte), 32'h83);
    cyc(4'hD, 1'b1); chk("pp_drain2", 32'(key_byte), 32'h84);
    cyc(4'hD, 1'b1); chk("pp_tail", 32'(key_byte), 32'h87);
    cyc(4'hD, 1'b1); chk("pp_drain4", 32'(key_byte), 32'h0D);
    cyc(4'hD, 1'b1);
    chk("pop_empty_count", 32'(count), 0);
    chk("pop_empty_byte", 32'(key_byte), 32'h0D);
    chk("pop_empty_ovf", 32'(overflow), 0);
    for (int i = 0; i < 3; i++) cyc(4'h9, 1'b0);
    cyc(4'h9, 1'b1);
    chk("pp_empty_count", 32'(count), 1);
    chk("pp_empty_byte", 32'(key_byte), 32'h89);
    cyc(4'hD, 1'b1);
    for (int i = 0; i < 3; i++) cyc(4'hD, 1'b0);

    // reset while holding with entries and overflow pending
    press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h6);
    for (int i = 0; i < 4; i++) cyc(4'h5, 1'b0);
    chk("held_full_count", 32'(count), 4);
    cyc(4'h5, 1'b1);
    chk("held_count3", 32'(count), 3);
    chk("held_head", 32'(key_byte), 32'h82);
    cyc(4'h5, 1'b0);
    do_reset(4'h5);
    chk("mid_rst_byte", 32'(key_byte), 32'h0D);
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_ovf", 32'(overflow), 0);
    chk("mid_rst_empty", 32'(empty), 1);
    for (int i = 0; i < 3; i++) cyc(4'h5, 1'b0);
    chk("post_rst_wait", 32'(count), 0);
    cyc(4'h5, 1'b0);
    chk("post_rst_count", 32'(count), 1);
    chk("post_rst_byte", 32'(key_byte), 32'h85);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
